// File: rtl/rv32i_pkg.sv
// rtl/rv32i_pkg.sv - shared fetch-stage types and the default bubble instruction
package rv32i_pkg;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2,
        DROP = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/if_id_fetch_if.sv
// rtl/if_id_fetch_if.sv - instruction-memory request/response bundle between fetch and memory
interface if_id_fetch_if #(
    parameter int PC_W = 20
);
    logic            imem_req;
    logic [PC_W-1:0] imem_addr;
    logic            imem_ack;
    logic [31:0]     imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/if_id_fetch.sv
// rtl/if_id_fetch.sv - IF stage fetch FSM with IF/ID register; IF_ID_FETCH_PERF_CNT_EN adds stall/flush counters
module if_id_fetch
    import rv32i_pkg::*;
#(
    parameter int          PC_W      = 20,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [PC_W-1:0] IF_PC,
    input  logic            IFIDWrite,
    input  logic            IF_Flush,
    if_id_fetch_if.master   imem,
    output logic            pc_advance,
    output logic [PC_W-1:0] ID_PC,
    output logic [31:0]     ID_instr,
    output logic            ID_valid
`ifdef IF_ID_FETCH_PERF_CNT_EN
    ,
    output logic [31:0]     stall_cycles,
    output logic [31:0]     flush_count
`endif
);

    fetch_state_t    r_state;
    fetch_state_t    w_next_state;
    logic            r_req;
    logic [PC_W-1:0] r_addr;
    logic [PC_W-1:0] r_hold_pc;
    logic [31:0]     r_hold_instr;
    logic [PC_W-1:0] r_id_pc;
    logic [31:0]     r_id_instr;
    logic            r_id_valid;
    logic            w_issue;
    logic            w_retire;
    logic            w_take_mem;
    logic            w_take_hold;
    logic            w_fill_hold;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_req   <= 1'b0;
            r_addr  <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_issue) begin
                r_req  <= 1'b1;
                r_addr <= IF_PC;
            end else if (w_retire) begin
                r_req  <= 1'b0;
            end
        end
    end

    // A request, once raised, stays up until acked even if the fetch is squashed (DROP).
    always_comb begin
        w_next_state = r_state;
        w_issue      = 1'b0;
        w_retire     = 1'b0;
        w_take_mem   = 1'b0;
        w_take_hold  = 1'b0;
        w_fill_hold  = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (!IF_Flush) begin
                    w_issue      = 1'b1;
                    w_next_state = WAIT;
                end
            end
            WAIT: begin
                if (imem.imem_ack) begin
                    w_retire     = 1'b1;
                    w_next_state = IDLE;
                    if (!IF_Flush) begin
                        if (IFIDWrite) begin
                            w_take_mem   = 1'b1;
                        end else begin
                            w_fill_hold  = 1'b1;
                            w_next_state = HOLD;
                        end
                    end
                end else if (IF_Flush) begin
                    w_next_state = DROP;
                end
            end
            HOLD: begin
                if (IF_Flush) begin
                    w_next_state = IDLE;
                end else if (IFIDWrite) begin
                    w_take_hold  = 1'b1;
                    w_next_state = IDLE;
                end
            end
            DROP: begin
                if (imem.imem_ack) begin
                    w_retire     = 1'b1;
                    w_next_state = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_hold_pc    <= '0;
            r_hold_instr <= '0;
        end else if (w_fill_hold) begin
            r_hold_pc    <= r_addr;
            r_hold_instr <= imem.imem_rdata;
        end
    end

    // Flush wins over everything; with nothing to deliver, a permitted load becomes a bubble.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_id_pc    <= '0;
            r_id_instr <= NOP_INSTR;
            r_id_valid <= 1'b0;
        end else if (IF_Flush) begin
            r_id_instr <= NOP_INSTR;
            r_id_valid <= 1'b0;
        end else if (w_take_mem) begin
            r_id_pc    <= r_addr;
            r_id_instr <= imem.imem_rdata;
            r_id_valid <= 1'b1;
        end else if (w_take_hold) begin
            r_id_pc    <= r_hold_pc;
            r_id_instr <= r_hold_instr;
            r_id_valid <= 1'b1;
        end else if (IFIDWrite) begin
            r_id_instr <= NOP_INSTR;
            r_id_valid <= 1'b0;
        end
    end

`ifdef IF_ID_FETCH_PERF_CNT_EN
    logic [31:0] r_stall_cycles;
    logic [31:0] r_flush_count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_stall_cycles <= '0;
            r_flush_count  <= '0;
        end else begin
            if (r_state != IDLE) begin
                r_stall_cycles <= r_stall_cycles + 32'd1;
            end
            if (IF_Flush) begin
                r_flush_count <= r_flush_count + 32'd1;
            end
        end
    end

    assign stall_cycles = r_stall_cycles;
    assign flush_count  = r_flush_count;
`endif

    assign imem.imem_req  = r_req;
    assign imem.imem_addr = r_addr;
    assign pc_advance     = w_take_mem | w_take_hold;
    assign ID_PC          = r_id_pc;
    assign ID_instr       = r_id_instr;
    assign ID_valid       = r_id_valid;

endmodule

// File: doc/if_id_fetch.md
IF_ID_FETCH -- requirements
Module: if_id_fetch

Interface
REQ-001 SHALL have parameter PC_W, default 20, meaning PC and instruction-memory address width.
REQ-002 SHALL have parameter NOP_INSTR, default 32'h0000_0013, meaning the instruction driven on ID_instr for a bubble.
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port IF_PC  input  PC_W  current fetch PC from the PC register.
REQ-006 SHALL have port IFIDWrite  input  1  hazard unit permits the ID register to load.
REQ-007 SHALL have port IF_Flush  input  1  branch or jump redirect; squash the fetch path.
REQ-008 SHALL have port imem_req  output  1  instruction-memory request, registered.
REQ-009 SHALL have port imem_addr  output  PC_W  request address, registered.
REQ-010 SHALL have port imem_ack  input  1  memory returns data this cycle; variable latency.
REQ-011 SHALL have port imem_rdata  input  32  instruction word, valid when imem_ack=1.
REQ-012 SHALL have port pc_advance  output  1  combinational; high only in the cycle the ID register loads a fetched instruction; drives the PC register's PCWrite.
REQ-013 SHALL have ports ID_PC (PC_W), ID_instr (32) and ID_valid (1), all outputs; together they form the registered IF/ID stage.

Function
REQ-014 SHALL implement an FSM with states IDLE, WAIT, HOLD and DROP.
REQ-015 In IDLE without IF_Flush, the next edge SHALL latch imem_addr<=IF_PC, set imem_req<=1 and go to WAIT. With IF_Flush, the FSM SHALL stay in IDLE for that edge so the redirected PC is used.
REQ-016 In WAIT, imem_req and imem_addr SHALL hold until imem_ack. A request SHALL never be withdrawn before ack.
REQ-017 On WAIT with ack, no flush and IFIDWrite=1, the block SHALL load ID_PC<=imem_addr, ID_instr<=imem_rdata and ID_valid<=1, drop imem_req, go to IDLE, and assert pc_advance.
REQ-018 On WAIT with ack, no flush and IFIDWrite=0, the block SHALL capture the address and data in a hold buffer, drop imem_req and go to HOLD.
REQ-019 In HOLD with IFIDWrite=1 and no flush, the block SHALL load the ID register from the buffer, assert pc_advance and go to IDLE.
REQ-020 IF_Flush in WAIT without ack SHALL cause a move to DROP. DROP SHALL keep the request up, discard the data on ack and go to IDLE. pc_advance SHALL stay 0.
REQ-021 IF_Flush with ack in WAIT, or IF_Flush in HOLD, SHALL discard the data and go to IDLE.
REQ-022 Whenever IF_Flush=1, the next edge SHALL set ID_valid<=0 and ID_instr<=NOP_INSTR. Flush SHALL override IFIDWrite.
REQ-023 When IFIDWrite=1 with no instruction available, the ID register SHALL load a bubble: ID_valid=0, ID_instr=NOP_INSTR, ID_PC unchanged.
REQ-024 When IFIDWrite=0 and there is no flush, the ID register SHALL hold its value.
REQ-025 Throughput SHALL be one instruction per 2 cycles with a zero-wait memory. Latency from IDLE to ID_valid SHALL be 2 edges plus memory wait cycles.

Reset
REQ-026 reset_n=0 SHALL immediately force FSM=IDLE, imem_req=0, imem_addr=0, ID_PC=0, ID_instr=NOP_INSTR, ID_valid=0 and hold buffer=0.
REQ-027 Reset during WAIT SHALL abandon the outstanding request. The memory model SHALL tolerate a dropped request.

Configuration
REQ-028 With macro IF_ID_FETCH_PERF_CNT_EN defined, the block SHALL add outputs stall_cycles[31:0] and flush_count[31:0], both reset to 0, wrapping at 2^32.
- stall_cycles SHALL increment each cycle in WAIT, HOLD or DROP.
- flush_count SHALL increment each cycle IF_Flush=1.
REQ-029 Without IF_ID_FETCH_PERF_CNT_EN, those ports and counters SHALL be absent and behaviour SHALL be otherwise identical.

Structure
REQ-030 The FSM state typedef and the NOP_INSTR default SHALL live in the shared package rv32i_pkg.
REQ-031 The block SHALL be a single module with no sub-module. The hold buffer SHALL be inline registers.

Verification
REQ-032 Reset, then IF_PC=0x00010 with ack on the first WAIT cycle and rdata=0x00500093 -> ID_PC=0x00010, ID_instr=0x00500093, ID_valid=1 two edges after reset release; pc_advance pulses once.
REQ-033 Ack after 3 wait cycles -> imem_req and imem_addr stable for all 4 WAIT cycles; no pc_advance until the ack cycle.
REQ-034 IFIDWrite=0 at ack, rdata=0x00208133, then IFIDWrite=1 two cycles later -> HOLD for 2 cycles, then ID_instr=0x00208133 with pc_advance on the release cycle.
REQ-035 IF_Flush in WAIT 1 cycle before ack -> DROP; data discarded; ID_valid=0, ID_instr=0x00000013; pc_advance=0 throughout.
REQ-036 Assert reset_n=0 mid-WAIT -> outputs reach their reset values without a clock edge; with IF_ID_FETCH_PERF_CNT_EN defined, the counters read 0.
